// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the fetch/memory single-port RAM arbiter.
package mem_arb_pkg;

   localparam int ADDR_W_DEF     = 7;
   localparam int DATA_W_DEF     = 32;
   localparam int STARVE_MAX_DEF = 3;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } arb_state_t;

   typedef enum logic {
      FETCH = 1'b0,
      MEM   = 1'b1
   } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared instruction/data RAM between the fetch and memory stages.
// Memory stage has priority; a grant streak counter guarantees fetch progress.
//
//   state | meaning
//   IDLE  | no access in flight; pick a winner and issue it this cycle
//   RESP  | RAM read data valid; owner sees ready, always back to IDLE
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   input  logic              fetch_cancel,
   output logic [DATA_W-1:0] fetch_rdata,
   output logic              fetch_ready,
   output logic              fetch_stall,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ready,
   output logic              mem_stall,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);

   arb_state_t state, state_nxt;
   arb_owner_t owner, owner_nxt;
   logic [3:0] streak, streak_nxt;
   logic       fetch_ok;
   logic       grant;
   logic       win_mem;

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         owner  <= FETCH;
         streak <= '0;
      end else begin
         state  <= state_nxt;
         owner  <= owner_nxt;
         streak <= streak_nxt;
      end
   end

   // A cancelled fetch is not eligible for a grant in the same cycle.
   always_comb begin
      fetch_ok   = fetch_req & ~fetch_cancel;
      grant      = (state == IDLE) & (fetch_ok | mem_req);
      win_mem    = mem_req & (~fetch_ok | (streak != STREAK_MAX));
      state_nxt  = state;
      owner_nxt  = owner;
      streak_nxt = streak;

      case (state)
         IDLE: begin
            if (grant) begin
               state_nxt = RESP;
               owner_nxt = win_mem ? MEM : FETCH;
            end
         end
         RESP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      if (!fetch_req) begin
         streak_nxt = '0;
      end else if (grant && !win_mem) begin
         streak_nxt = '0;
      end else if (grant && win_mem && (streak != STREAK_MAX)) begin
         streak_nxt = streak + 4'd1;
      end
   end

   // Everything is held low during reset so a dropped access cannot leak out.
   always_comb begin
      ram_en      = 1'b0;
      ram_we      = 1'b0;
      ram_addr    = '0;
      ram_wdata   = '0;
      fetch_ready = 1'b0;
      fetch_rdata = '0;
      fetch_stall = 1'b0;
      mem_ready   = 1'b0;
      mem_rdata   = '0;
      mem_stall   = 1'b0;

      if (!reset) begin
         if (grant) begin
            ram_en = 1'b1;
            if (win_mem) begin
               ram_we    = mem_we;
               ram_addr  = mem_addr;
               ram_wdata = mem_wdata;
            end else begin
               ram_addr  = fetch_addr;
            end
         end

         if (state == RESP) begin
            if (owner == MEM) begin
               mem_ready = 1'b1;
               mem_rdata = ram_rdata;
            end else begin
               fetch_ready = ~fetch_cancel;
               fetch_rdata = ram_rdata;
            end
         end

         fetch_stall = fetch_req & ~fetch_ready;
         mem_stall   = mem_req & ~mem_ready;
      end
   end

endmodule
